fetch_prefetch_queue: RTL

FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

---
 rtl/fetch_prefetch_queue.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from a single-outstanding
// memory port into a small FIFO and presents the head (or an injected word) to decode.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h7800_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     restore,
    input  logic [31:0]              PC_before_int,
    input  logic                     stall,
    input  logic                     use_cpu_injection,
    input  logic [31:0]              cpu_injection,
    input  logic                     use_INT_INSTR,
    input  logic [31:0]              INT_INSTR,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic [31:0]              instr,
    output logic                     instr_valid,
    output logic [31:0]              current_PC,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_instr [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_flush;
    logic [31:0]   w_flush_pc;
    logic          w_inj;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_space;

    assign w_flush     = redirect | restore;
    assign w_flush_pc  = restore ? PC_before_int : redirect_pc;
    assign w_inj       = use_cpu_injection | use_INT_INSTR;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    // Responses landing in a flush cycle belong to the abandoned stream.
    assign w_push      = (r_state == WAIT) & mem_rvalid & ~w_flush & ~w_full;
    assign w_pop       = ~w_empty & ~stall & ~w_inj & ~w_flush;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_space     = (w_count_nxt < CW'(DEPTH));

    assign mem_addr = r_pc;
    assign q_count  = r_count;

    // Fetch FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch FSM next state and request output
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_flush || w_space) w_state_nxt = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt)      w_state_nxt = w_flush ? DROP : WAIT;
                else if (w_flush) w_state_nxt = IDLE;
            end
            WAIT: begin
                if (w_flush)         w_state_nxt = mem_rvalid ? REQ : DROP;
                else if (mem_rvalid) w_state_nxt = w_space ? REQ : IDLE;
            end
            DROP: begin
                if (mem_rvalid) w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Fetch PC: flush target wins over sequential advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_flush) begin
            r_pc <= w_flush_pc;
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
        end
    end

    // Queue storage needs no reset; occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wptr]    <= r_pc;
            r_q_instr[r_wptr] <= mem_rdata;
        end
    end

    // Presentation mux: injections override the queue head
    always_comb begin
        instr       = NOP_INSTR;
        instr_valid = 1'b0;
        current_PC  = w_empty ? r_pc : r_q_pc[r_rptr];
        if (use_cpu_injection) begin
            instr       = cpu_injection;
            instr_valid = 1'b1;
        end else if (use_INT_INSTR) begin
            instr       = INT_INSTR;
            instr_valid = 1'b1;
        end else if (!w_empty && !w_flush) begin
            instr       = r_q_instr[r_rptr];
            instr_valid = 1'b1;
        end
    end

endmodule
